// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream arbiter: N requesters share one master port.
// Grants are packet-locked (held from first beat through tlast) and rotate
// starting after the requester that finished the previous packet. A single
// output register decouples the master side and sustains one beat per cycle.
module axis_rr_arbiter #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDW        = 2
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [N-1:0]            s_axis_tvalid,
   output logic [N-1:0]            s_axis_tready,
   input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [N-1:0]            s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tlast,
   output logic [IDW-1:0]          m_axis_tid
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [IDW-1:0]        sel, sel_nxt;
   logic [IDW-1:0]        last, last_nxt;

   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  out_free;
   logic                  accept;

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;
   logic [IDW-1:0]        tid_p1;

   // Round-robin pick: lowest requesting index above prev, else lowest
   // requesting index at or below prev (wrap-around).
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [IDW-1:0] prev);
      logic [IDW-1:0] pick_hi;
      logic [IDW-1:0] pick_lo;
      logic           found_hi;
      pick_hi  = '0;
      pick_lo  = '0;
      found_hi = 1'b0;
      // Descending scan so the final assignment in each group is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i > int'(prev)) begin
               pick_hi  = IDW'(i);
               found_hi = 1'b1;
            end else begin
               pick_lo  = IDW'(i);
            end
         end
      end
      return found_hi ? pick_hi : pick_lo;
   endfunction

   // Route the granted requester's valid/data/last onto common wires.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == IDW'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The output register can take a new beat when empty or draining this cycle.
   assign out_free = !vld_p1 || m_axis_tready;

   // Next-state, grant and slave-side ready logic.
   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      last_nxt      = last;
      s_axis_tready = '0;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (|s_axis_tvalid) begin
               sel_nxt   = rr_pick(s_axis_tvalid, last);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < N; i++) begin
               s_axis_tready[i] = (sel == IDW'(i)) && out_free;
            end
            accept = sel_valid && out_free;
            // Grant is released only by the packet's final beat.
            if (accept && sel_last) begin
               last_nxt  = sel;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration state register; last starts at N-1 so requester 0 wins first.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
         sel   <= '0;
         last  <= IDW'(N - 1);
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         last  <= last_nxt;
      end
   end

   // Output register stage: load on accept, drop valid when drained.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
         tid_p1  <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= sel_data;
         last_p1 <= sel_last;
         tid_p1  <= sel;
      end else if (m_axis_tready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign m_axis_tvalid = vld_p1;
   assign m_axis_tdata  = data_p1;
   assign m_axis_tlast  = last_p1;
   assign m_axis_tid    = tid_p1;

endmodule
